// File: rtl/aes_pkg.sv
//------------------------------------------------------------------------------
// Module      : aes_pkg
// Description : Shared widths, FSM state type and FIPS-197 forward S-box.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package aes_pkg;

   localparam int TEXT_WIDTH = 128;
   localparam int BYTE_WIDTH = 8;
   localparam int S_BOX_SIZE = 256;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      DONE = 2'd2
   } fsm_state_t;

   localparam logic [7:0] S_BOX [0:S_BOX_SIZE-1] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

endpackage

`default_nettype wire

// File: rtl/s_box_lane.sv
//------------------------------------------------------------------------------
// Module      : s_box_lane
// Description : One 8-bit S-box lookup; table is the shared writable copy when
//               S_BOX_LOAD_EN is defined, otherwise the constant FIPS-197 table.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module s_box_lane
   import aes_pkg::*;
(
`ifdef S_BOX_LOAD_EN
   input  logic [S_BOX_SIZE*BYTE_WIDTH-1:0] sbox_table_i,
`endif
   input  logic [BYTE_WIDTH-1:0]            byte_i,
   output logic [BYTE_WIDTH-1:0]            byte_o
);

`ifdef S_BOX_LOAD_EN
   // Entry n lives at bits [n*8 +: 8] of the flattened table.
   assign byte_o = sbox_table_i[{byte_i, 3'b000} +: BYTE_WIDTH];
`else
   assign byte_o = S_BOX[byte_i];
`endif

endmodule

`default_nettype wire

// File: rtl/sub_bytes_engine.sv
//------------------------------------------------------------------------------
// Module      : sub_bytes_engine
// Description : Iterative AES SubBytes, BYTES_PER_CYCLE bytes per beat, valid/
//               ready on both sides. S_BOX_LOAD_EN adds a writable S-box table.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sub_bytes_engine
   import aes_pkg::*;
#(
   parameter int BYTES_PER_CYCLE = 4
)
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [TEXT_WIDTH-1:0] plaintext_temp_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic [TEXT_WIDTH-1:0] plaintext_temp_o,
   output logic                  valid_o,
   input  logic                  ready_i
`ifdef S_BOX_LOAD_EN
  ,input  logic                  sbox_we_i,
   input  logic [7:0]            sbox_addr_i,
   input  logic [7:0]            sbox_data_i
`endif
);

   localparam int BEATS = TEXT_WIDTH / BYTE_WIDTH / BYTES_PER_CYCLE;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(BEATS - 1);

   if (!(BYTES_PER_CYCLE inside {1, 2, 4, 8, 16})) begin : g_bad_bpc
      $error("sub_bytes_engine: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   fsm_state_t            r_fsm;
   fsm_state_t            w_fsm_next;
   logic [CNT_W-1:0]      r_beat;
   logic [TEXT_WIDTH-1:0] r_data;
   logic [TEXT_WIDTH-1:0] w_data_sub;
   logic [4:0]            w_base;
   logic [6:0]            w_lsb      [BYTES_PER_CYCLE];
   logic [BYTE_WIDTH-1:0] w_lane_in  [BYTES_PER_CYCLE];
   logic [BYTE_WIDTH-1:0] w_lane_out [BYTES_PER_CYCLE];

`ifdef S_BOX_LOAD_EN
   logic [BYTE_WIDTH-1:0]            r_sbox [S_BOX_SIZE];
   logic [S_BOX_SIZE*BYTE_WIDTH-1:0] w_sbox_flat;

   // Writes land on the same edge as an acceptance, so the first beat sees them.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int a = 0; a < S_BOX_SIZE; a++) r_sbox[a] <= S_BOX[a];
      end else if (sbox_we_i && (r_fsm == IDLE)) begin
         r_sbox[sbox_addr_i] <= sbox_data_i;
      end
   end

   always_comb begin
      w_sbox_flat = '0;
      for (int a = 0; a < S_BOX_SIZE; a++) w_sbox_flat[a*BYTE_WIDTH +: BYTE_WIDTH] = r_sbox[a];
   end
`endif

   // Byte 0 sits at the MSB end, so byte n starts at bit 8*(15-n).
   assign w_base = 5'(r_beat) * 5'(BYTES_PER_CYCLE);

   for (genvar k = 0; k < BYTES_PER_CYCLE; k++) begin : g_lane
      logic [3:0] w_idx;
      assign w_idx        = 4'(w_base + 5'(k));
      assign w_lsb[k]     = {~w_idx, 3'b000};
      assign w_lane_in[k] = r_data[w_lsb[k] +: BYTE_WIDTH];

      s_box_lane u_lane (
`ifdef S_BOX_LOAD_EN
         .sbox_table_i (w_sbox_flat),
`endif
         .byte_i       (w_lane_in[k]),
         .byte_o       (w_lane_out[k])
      );
   end

   always_comb begin
      w_data_sub = r_data;
      for (int k = 0; k < BYTES_PER_CYCLE; k++) w_data_sub[w_lsb[k] +: BYTE_WIDTH] = w_lane_out[k];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_fsm <= IDLE;
      end else begin
         r_fsm <= w_fsm_next;
      end
   end

   always_comb begin
      w_fsm_next = r_fsm;
      case (r_fsm)
         IDLE:    if (valid_i) w_fsm_next = SUB;
         SUB:     if (r_beat == c_last_beat) w_fsm_next = DONE;
         DONE:    if (ready_i) w_fsm_next = IDLE;
         default: w_fsm_next = IDLE;
      endcase
   end

   always_comb begin
      ready_o = 1'b0;
      valid_o = 1'b0;
      case (r_fsm)
         IDLE:    ready_o = 1'b1;
         DONE:    valid_o = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_data <= '0;
         r_beat <= '0;
      end else begin
         case (r_fsm)
            IDLE: begin
               if (valid_i) begin
                  r_data <= plaintext_temp_i;
                  r_beat <= '0;
               end
            end
            SUB: begin
               r_data <= w_data_sub;
               if (r_beat != c_last_beat) r_beat <= r_beat + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign plaintext_temp_o = r_data;

endmodule

`default_nettype wire
